// File: rtl/axi_read_responder_pkg.sv
// rtl/axi_read_responder_pkg.sv - shared AXI read request types and widths
package axi_read_responder_pkg;

  localparam int ADDR_WIDTH      = 32;
  localparam int DATA_WIDTH      = 32;
  localparam int LEN_WIDTH       = 8;
  localparam int ID_WIDTH        = 4;
  localparam int REQ_INDEX_WIDTH = 32;

  // Index is kept at full address width so d_cache benches can reuse the type
  // regardless of the memory depth they instantiate.
  typedef struct packed {
    logic [REQ_INDEX_WIDTH-1:0] index;
    logic [LEN_WIDTH-1:0]       len;
    logic [ID_WIDTH-1:0]        id;
  } axi_req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LATENCY,
    ST_BURST
  } rd_state_t;

  function automatic logic [LEN_WIDTH-1:0] burst_beats(input logic [LEN_WIDTH-1:0] len);
    return (len == '0) ? LEN_WIDTH'(1) : len;
  endfunction

endpackage

// File: rtl/cache_bank.sv
// rtl/cache_bank.sv - word memory with one write port and one synchronous read port
module cache_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Read-before-write: a same-cycle read of the written index returns old data.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_read_responder.sv
// rtl/axi_read_responder.sv - memory-side AXI read responder with request queue,
// programmable latency and a 2-entry R skid buffer
module axi_read_responder
  import axi_read_responder_pkg::*;
#(
  parameter int MEM_INDEX_WIDTH = 14,
  parameter int READ_LATENCY    = 4,
  parameter int REQ_DEPTH       = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_WIDTH-1:0]      ARADDR,
  input  logic [LEN_WIDTH-1:0]       ARLEN,
  input  logic [ID_WIDTH-1:0]        ARID,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  output logic [DATA_WIDTH-1:0]      RDATA,
  output logic [ID_WIDTH-1:0]        RID,
  output logic                       RLAST,
  output logic                       RVALID,
  input  logic                       RREADY,
  input  logic                       load_we,
  input  logic [MEM_INDEX_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0]      load_data
);

  localparam int             QW       = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam logic [QW:0]    Q_FULL   = (QW+1)'(REQ_DEPTH);
  localparam logic [7:0]     LAT_INIT = 8'(READ_LATENCY);

  logic [MEM_INDEX_WIDTH-1:0] r_q_index [REQ_DEPTH];
  logic [LEN_WIDTH-1:0]       r_q_len   [REQ_DEPTH];
  logic [ID_WIDTH-1:0]        r_q_id    [REQ_DEPTH];
  logic [QW-1:0]              r_q_wptr, r_q_rptr;
  logic [QW:0]                r_q_count;
  logic                       r_arready;
  logic                       w_push, w_pop, w_q_empty;
  logic [QW:0]                w_q_count_nxt;
  logic                       w_unused_addr;

  rd_state_t                  r_state, w_state_nxt;
  logic [7:0]                 r_lat, w_lat_nxt;
  logic [LEN_WIDTH-1:0]       r_beat, w_beat_nxt;
  logic [MEM_INDEX_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [ID_WIDTH-1:0]        r_id, w_id_nxt;
  logic                       w_issue;

  logic                       r_pend, r_pend_last;
  logic [ID_WIDTH-1:0]        r_pend_id;
  logic [DATA_WIDTH-1:0]      r_buf_data [2];
  logic [ID_WIDTH-1:0]        r_buf_id   [2];
  logic                       r_buf_last [2];
  logic                       r_buf_head, r_buf_tail;
  logic [1:0]                 r_buf_cnt;
  logic                       w_from_buf, w_can_read, w_buf_push, w_buf_pop;
  logic [DATA_WIDTH-1:0]      w_mem_rdata;

  assign w_unused_addr = ^ARADDR;
  assign ARREADY       = r_arready;
  assign w_push        = ARVALID & r_arready;
  assign w_q_empty     = (r_q_count == '0);
  assign w_q_count_nxt = r_q_count + (QW+1)'(w_push) - (QW+1)'(w_pop);

  // ARREADY follows the registered occupancy, so a pop on a full queue only
  // reopens the slot on the following cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q_wptr  <= '0;
      r_q_rptr  <= '0;
      r_q_count <= '0;
      r_arready <= 1'b0;
    end else begin
      if (w_push) r_q_wptr <= r_q_wptr + QW'(1);
      if (w_pop)  r_q_rptr <= r_q_rptr + QW'(1);
      r_q_count <= w_q_count_nxt;
      r_arready <= (w_q_count_nxt != Q_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_index[r_q_wptr] <= ARADDR[2 +: MEM_INDEX_WIDTH];
      r_q_len[r_q_wptr]   <= ARLEN;
      r_q_id[r_q_wptr]    <= ARID;
    end
  end

  // Reads in flight plus buffered beats never exceed the two buffer slots.
  assign w_from_buf = (r_buf_cnt != 2'd0);
  assign w_can_read = (r_buf_cnt == 2'd0) || ((r_buf_cnt == 2'd1) && !r_pend);

  always_comb begin
    w_state_nxt = r_state;
    w_lat_nxt   = r_lat;
    w_beat_nxt  = r_beat;
    w_addr_nxt  = r_addr;
    w_id_nxt    = r_id;
    w_issue     = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: w_pop = !w_q_empty;
      ST_LATENCY: begin
        if (r_lat <= 8'd1) w_state_nxt = ST_BURST;
        else               w_lat_nxt   = r_lat - 8'd1;
      end
      ST_BURST: begin
        if (w_can_read) begin
          w_issue    = 1'b1;
          w_addr_nxt = r_addr + MEM_INDEX_WIDTH'(1);
          w_beat_nxt = r_beat - LEN_WIDTH'(1);
          if (r_beat == LEN_WIDTH'(1)) begin
            w_state_nxt = ST_IDLE;
            w_pop       = !w_q_empty;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_pop) begin
      w_addr_nxt  = r_q_index[r_q_rptr];
      w_beat_nxt  = burst_beats(r_q_len[r_q_rptr]);
      w_id_nxt    = r_q_id[r_q_rptr];
      w_lat_nxt   = LAT_INIT;
      w_state_nxt = (READ_LATENCY == 0) ? ST_BURST : ST_LATENCY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_lat   <= '0;
      r_beat  <= '0;
      r_addr  <= '0;
      r_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lat   <= w_lat_nxt;
      r_beat  <= w_beat_nxt;
      r_addr  <= w_addr_nxt;
      r_id    <= w_id_nxt;
    end
  end

  cache_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (MEM_INDEX_WIDTH)
  ) u_bank (
    .clk     (clk),
    .i_we    (load_we),
    .i_waddr (load_addr),
    .i_wdata (load_data),
    .i_re    (w_issue),
    .i_raddr (r_addr),
    .o_rdata (w_mem_rdata)
  );

  // A returning read is shown directly when the buffer is empty; it is only
  // parked in the buffer when it cannot be handed over this cycle.
  assign RVALID     = w_from_buf | r_pend;
  assign w_buf_push = r_pend & (w_from_buf | ~RREADY);
  assign w_buf_pop  = w_from_buf & RREADY;

  always_comb begin
    RDATA = '0;
    RID   = '0;
    RLAST = 1'b0;
    if (w_from_buf) begin
      RDATA = r_buf_data[r_buf_head];
      RID   = r_buf_id[r_buf_head];
      RLAST = r_buf_last[r_buf_head];
    end else if (r_pend) begin
      RDATA = w_mem_rdata;
      RID   = r_pend_id;
      RLAST = r_pend_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend      <= 1'b0;
      r_pend_id   <= '0;
      r_pend_last <= 1'b0;
      r_buf_head  <= 1'b0;
      r_buf_tail  <= 1'b0;
      r_buf_cnt   <= 2'd0;
    end else begin
      r_pend      <= w_issue;
      r_pend_id   <= r_id;
      r_pend_last <= (r_beat == LEN_WIDTH'(1));
      if (w_buf_push) r_buf_tail <= ~r_buf_tail;
      if (w_buf_pop)  r_buf_head <= ~r_buf_head;
      r_buf_cnt   <= r_buf_cnt + {1'b0, w_buf_push} - {1'b0, w_buf_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_buf_push) begin
      r_buf_data[r_buf_tail] <= w_mem_rdata;
      r_buf_id[r_buf_tail]   <= r_pend_id;
      r_buf_last[r_buf_tail] <= r_pend_last;
    end
  end

endmodule
